operand_load_sequencer: RTL and testbench

- Parametrised Moore sequencer that steers operand capture for the arithmetic datapath.
- Walks through NUM_OPS operand-entry phases on user `rdy` edges, then fires a one-cycle compute strobe. It waits for the math unit's `calc_done` and pulses `done`.
- Sits between the debounced key/entry front end and the operand registers plus compute unit. It generalises the fixed A/B/M loader to N operands, with an abort path, a completion handshake and an optional timeout.

---
 rtl/operand_load_sequencer.sv | 94 +++++++++
 tb/tb_operand_load_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/operand_load_sequencer.sv
// operand_load_sequencer: steps through NUM_OPS operand-entry phases on rdy edges,
// strobes the compute unit, waits for calc_done and pulses done.
// Optional WAIT_RES timeout is built when OPSEQ_TIMEOUT_EN is defined.
module operand_load_sequencer #(
    parameter int NUM_OPS        = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDX_W          = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               abort,
    input  logic               calc_done,
    output logic [NUM_OPS-1:0] load_op,
    output logic               load_m,
    output logic [IDX_W-1:0]   op_idx,
    output logic               busy,
    output logic               done,
    output logic               err
);
    typedef enum logic [2:0] {IDLE, OP, LOAD_M, WAIT_RES, DONE} state_t;
    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             rdy_q;
    logic             rdy_edge;
    logic             tmo;
    assign rdy_edge = rdy & ~rdy_q;
    // rdy_q follows rdy even during reset, so a rdy held high across reset release is not seen as an edge
    always_ff @(posedge clk)
        rdy_q <= rdy;
    // state and operand index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end
`ifdef OPSEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt;
    logic          err_q;
    assign tmo = (state == WAIT_RES) && !calc_done && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign err = err_q;
    // wait counter is held at zero outside WAIT_RES and counts cycles without calc_done inside it
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= (state != WAIT_RES) ? '0 : calc_done ? cnt : cnt + CW'(1);
            err_q <= tmo && !abort;
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif
    // next state: abort wins over everything outside IDLE
    always_comb begin
        state_n = state;
        idx_n   = idx;
        if (abort && state != IDLE) begin
            state_n = IDLE;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE:     if (rdy_edge) begin
                    state_n = OP;
                    idx_n   = '0;
                end
                OP:       if (rdy_edge) begin
                    state_n = (idx == IDX_W'(NUM_OPS - 1)) ? LOAD_M : OP;
                    idx_n   = (idx == IDX_W'(NUM_OPS - 1)) ? '0 : idx + IDX_W'(1);
                end
                LOAD_M:   state_n = WAIT_RES;
                WAIT_RES: state_n = calc_done ? DONE : tmo ? IDLE : WAIT_RES;
                default:  state_n = IDLE;
            endcase
        end
    end
    // Moore outputs decoded from registered state and idx
    always_comb begin
        load_op = '0;
        for (int i = 0; i < NUM_OPS; i++)
            load_op[i] = (state == OP) && (idx == IDX_W'(i));
        load_m = state == LOAD_M;
        op_idx = (state == OP) ? idx : '0;
        busy   = state != IDLE;
        done   = state == DONE;
    end
endmodule

// File: tb/tb_operand_load_sequencer.sv
// tb_operand_load_sequencer: table vectors, directed corner cases and random stimulus
// against a phase-counting reference model of operand_load_sequencer.
module tb_operand_load_sequencer;
    localparam int N  = 3;
    localparam int TC = 8;
`ifdef OPSEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rdy = 1'b0;
    logic         abort = 1'b0;
    logic         calc_done = 1'b0;
    logic [N-1:0] load_op;
    logic         load_m;
    logic [1:0]   op_idx;
    logic         busy;
    logic         done;
    logic         err;
    logic [8:0]   got;
    int           checks = 0;
    int           errors = 0;
    int           ph = 0;
    int           wt = 0;
    bit           prev_rdy = 1'b0;
    bit           m_err = 1'b0;
    typedef struct {
        logic       r;
        logic       a;
        logic       cd;
        logic [8:0] exp;
    } vec_t;
    vec_t tbl [15];
    operand_load_sequencer #(.NUM_OPS(N), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .abort(abort), .calc_done(calc_done),
        .load_op(load_op), .load_m(load_m), .op_idx(op_idx), .busy(busy),
        .done(done), .err(err)
    );
    assign got = {load_op, load_m, op_idx, busy, done, err};
    always #5 clk = ~clk;
    // phase 0 = idle, 1..N = operand ph-1, N+1 = compute strobe, N+2 = waiting, N+3 = done
    function automatic logic [8:0] model_out();
        logic [N-1:0] lo = '0;
        logic [1:0]   oi = '0;
        if (ph >= 1 && ph <= N) begin
            lo[ph-1] = 1'b1;
            oi = 2'(ph - 1);
        end
        return {lo, ph == N + 1, oi, ph != 0, ph == N + 3, m_err};
    endfunction
    task automatic model_step(input logic r, input logic a, input logic cd);
        bit e = r && !prev_rdy;
        prev_rdy = r;
        m_err = 1'b0;
        if (ph != 0 && a) ph = 0;
        else if (ph <= N) ph = ph + int'(e);
        else if (ph == N + 1) begin
            ph = N + 2;
            wt = 0;
        end else if (ph == N + 2) begin
            if (cd) ph = N + 3;
            else if (TMO_EN && wt == TC - 1) begin
                ph = 0;
                m_err = 1'b1;
            end else wt++;
        end else ph = 0;
    endtask
    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b ({load_op,load_m,op_idx,busy,done,err})", name, act, exp);
        end
    endtask
    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask
    task automatic step(input logic r, input logic a, input logic cd);
        rdy = r;
        abort = a;
        calc_done = cd;
        @(posedge clk);
        model_step(r, a, cd);
        @(negedge clk);
        check("model", got, model_out());
    endtask
    task automatic do_reset(input logic r);
        rst = 1'b1;
        rdy = r;
        abort = 1'b0;
        calc_done = 1'b0;
        @(posedge clk);
        ph = 0;
        wt = 0;
        prev_rdy = r;
        m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("reset", got, 9'b0);
    endtask
    task automatic run_to_wait();
        for (int i = 0; i <= N; i++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
    endtask
    initial begin
        int errs_seen;
        tbl[0]  = '{1, 0, 0, 9'b001_0_00_1_00};
        tbl[1]  = '{0, 0, 0, 9'b001_0_00_1_00};
        tbl[2]  = '{1, 0, 0, 9'b010_0_01_1_00};
        tbl[3]  = '{0, 0, 0, 9'b010_0_01_1_00};
        tbl[4]  = '{1, 0, 0, 9'b100_0_10_1_00};
        tbl[5]  = '{0, 0, 0, 9'b100_0_10_1_00};
        tbl[6]  = '{1, 0, 0, 9'b000_1_00_1_00};
        tbl[7]  = '{0, 0, 0, 9'b000_0_00_1_00};
        tbl[8]  = '{0, 0, 0, 9'b000_0_00_1_00};
        tbl[9]  = '{0, 0, 0, 9'b000_0_00_1_00};
        tbl[10] = '{0, 0, 0, 9'b000_0_00_1_00};
        tbl[11] = '{0, 0, 0, 9'b000_0_00_1_00};
        tbl[12] = '{0, 0, 1, 9'b000_0_00_1_10};
        tbl[13] = '{0, 0, 0, 9'b000_0_00_0_00};
        tbl[14] = '{0, 0, 1, 9'b000_0_00_0_00};
        @(negedge clk);
        do_reset(0);
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].a, tbl[i].cd);
            check($sformatf("table[%0d]", i), got, tbl[i].exp);
        end
        for (int i = 0; i < 20; i++) step(1, 0, 0);
        check("held_rdy_one_advance", got, 9'b001_0_00_1_00);
        step(0, 0, 0);
        step(1, 0, 0);
        check("op1_after_toggle", got, 9'b010_0_01_1_00);
        step(0, 0, 0);
        step(1, 1, 0);
        check("abort_with_edge", got, 9'b0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        check("abort_stays_idle", got, 9'b0);
        step(0, 0, 1);
        step(1, 0, 1);
        step(0, 0, 1);
        for (int i = 1; i <= N; i++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        step(0, 0, 0);
        step(0, 0, 0);
        check("stale_calc_done_ignored", got, 9'b000_0_00_1_00);
        step(0, 0, 1);
        check("fresh_calc_done", got, 9'b000_0_00_1_10);
        step(0, 0, 0);
        run_to_wait();
        errs_seen = 0;
        for (int i = 0; i < 120; i++) begin
            step(0, 0, 0);
            errs_seen += int'(err);
        end
        check1("timeout_busy", busy, !TMO_EN);
        checks++;
        if (errs_seen != int'(TMO_EN)) begin
            errors++;
            $display("FAIL timeout_err_pulses: got %0d expected %0d", errs_seen, int'(TMO_EN));
        end
        do_reset(0);
        run_to_wait();
        do_reset(1);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        check("rdy_held_through_reset", got, 9'b0);
        step(0, 0, 0);
        step(1, 0, 0);
        check("rdy_after_reset_toggle", got, 9'b001_0_00_1_00);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
            else step(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
